instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Instruction fetch stage of the CPU. Holds the program counter, reads one 32-bit instruction word per instruction over the memory bus, and presents it on `q` to the instruction decoder. It also sequences the decoder's `fetch` and `getRegs` strobes. It then waits for the execute stage to retire the instruction and select the next PC, either sequential or a jump target.

## Interface
Parameters:
- `ADDR_W`, 27: program-counter and bus address width (word addresses).
- `RESET_PC`, 0: PC value loaded on reset.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `nreset` in 1: asynchronous, active-low reset.
- `bus_addr` out ADDR_W: read address, equal to the PC or the prefetch address.
- `bus_start` out 1: one-cycle read request pulse.
- `bus_done` in 1: one-cycle pulse; `bus_q` is valid in the same cycle.
- `bus_q` in 32: read data.
- `q` out 32: instruction register contents, fed to the decoder.
- `fetch` out 1: decoder strobe, high for one cycle in FETCH.
- `getRegs` out 1: decoder strobe, high for one cycle in GETREGS.
- `pc` out ADDR_W: address of the instruction currently in `q`.
- `exec_done` in 1: execute stage has retired the current instruction.
- `jump_valid` in 1: qualified by `exec_done`; the next PC is `jump_addr`.
- `jump_addr` in ADDR_W: jump target.
- `halt` in 1: qualified by `exec_done`; stop fetching.
- `halted` out 1: the unit is in HALTED.

## Operation
States: RESET, REQ, WAIT, FETCH, GETREGS, HOLD, HALTED.
- RESET → REQ on the first clock after `nreset` deasserts.
- REQ: `bus_start`=1 and `bus_addr`=`pc`. Always → WAIT.
- WAIT: on `bus_done`, `ireg` <= `bus_q` and → FETCH. Otherwise stay in WAIT; there is no timeout.
- FETCH: `fetch`=1. → GETREGS.
- GETREGS: `getRegs`=1. → HOLD.
- HOLD: wait for `exec_done`.
  - If `halt` is also high: → HALTED. `halt` takes priority over `jump_valid`.
  - Else if `jump_valid` is high: `pc` <= `jump_addr`, → REQ.
  - Else: `pc` <= `pc`+1 modulo 2^ADDR_W, so all-ones wraps to 0. → REQ.
- HALTED: absorbing; only `nreset` leaves it. `halted`=1.
- `exec_done` is ignored in every state except HOLD.
- `bus_done` is ignored outside WAIT, or outside the prefetch-pending condition when prefetch is enabled.
- `q` = `ireg` at all times and is stable from FETCH until the next `bus_done` capture.
- Reset values: `pc`=`RESET_PC`, `ireg`=0, and `bus_start`, `fetch`, `getRegs`, `halted`=0. `bus_addr`=`RESET_PC`.
- Reset mid-transaction abandons any outstanding bus read. The memory controller shares the same reset.

## Timing
- `exec_done` sampled at edge n gives: REQ in cycle n+1, earliest `bus_done` in cycle n+2, `fetch` in cycle n+3, `getRegs` in cycle n+4.
- The memory returns `bus_done` no earlier than the cycle after `bus_start`.
- Exactly one outstanding bus read at any time.
- `fetch` and `getRegs` are registered outputs and are never high in the same cycle.

## Configuration
- `FETCH_PREFETCH_EN` defined:
  - On entering HOLD, the unit issues a speculative read of `pc`+1 into a one-word prefetch buffer.
  - On `exec_done` without a jump, and with the buffer valid: `ireg` <= buffer and → FETCH directly. The exec_done→`fetch` latency becomes 1 cycle.
  - If the buffer is still pending: → WAIT and consume the pending `bus_done`.
  - On a jump: the buffer is discarded. If a read is still outstanding, the unit waits for its `bus_done` and drops it before REQ.
  - On halt: the same drain happens, then → HALTED.
- `FETCH_PREFETCH_EN` undefined: no speculative reads, and behaviour is exactly as described above.

## Structure
- Shared package `cpu_fetch_pkg`: state enum `fetch_state_t`, `ADDR_W` default, `INSTR_W`=32.
- Sub-module `instr_prefetch_buf`: buffer data, valid and pending flags. Instantiated only under `FETCH_PREFETCH_EN`.

## Test plan
- Reset, `bus_done` one cycle after each `bus_start`, no jumps:
  - `bus_addr` sequence is 0,1,2.
  - `q` equals the memory words at those addresses.
  - `fetch` and then `getRegs` each pulse once per instruction.
- With `exec_done`+`jump_valid` and `jump_addr`=0x000_1234: next `bus_addr`=0x1234 and `pc`=0x1234.
- Preload `pc`=0x7FF_FFFF and retire with no jump: next `bus_addr`=0.
- Memory latency of 5 cycles: stays in WAIT, `q` unchanged until `bus_done`, and `fetch` follows 1 cycle later.
- `exec_done`+`halt`+`jump_valid` together: `halted`=1 and no further `bus_start`. Then assert `nreset` low mid-WAIT: all outputs return to reset values immediately.
- With `FETCH_PREFETCH_EN`:
  - Sequential code gives exec_done→`fetch` in 1 cycle.
  - A jump while the prefetch is outstanding drops the stale word and fetches the jump target.

Source files
------------

// File: rtl/cpu_fetch_pkg.sv
// Shared types and widths for the instruction fetch stage.
// The optional prefetch path is enabled by defining FETCH_PREFETCH_EN.
package cpu_fetch_pkg;

  localparam int ADDR_W_DEF = 27;
  localparam int INSTR_W    = 32;

  typedef enum logic [2:0] {
    ST_RESET   = 3'd0,
    ST_REQ     = 3'd1,
    ST_WAIT    = 3'd2,
    ST_FETCH   = 3'd3,
    ST_GETREGS = 3'd4,
    ST_HOLD    = 3'd5,
    ST_HALTED  = 3'd6
  } fetch_state_t;

endpackage

// File: rtl/instr_prefetch_buf.sv
// One-word speculative fetch buffer: data, valid and pending flags.
// Used by instr_fetch_unit only when FETCH_PREFETCH_EN is defined.
module instr_prefetch_buf
  import cpu_fetch_pkg::*;
(
  input  logic               clk,
  input  logic               nreset,
  input  logic               i_issue,
  input  logic               i_clear,
  input  logic               i_done,
  input  logic [INSTR_W-1:0] i_data,
  output logic [INSTR_W-1:0] o_data,
  output logic               o_valid,
  output logic               o_pending
);

  logic [INSTR_W-1:0] r_data;
  logic               r_valid;
  logic               r_pending;

  // NOTE: state is updated only with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_pending <= 1'b0;
    end else if (i_issue) begin
      r_pending <= 1'b1;
      r_valid   <= 1'b0;
    end else if (r_pending && i_done) begin
      r_pending <= 1'b0;
      r_valid   <= !i_clear;
      r_data    <= i_data;
    end else if (i_clear) begin
      r_valid   <= 1'b0;
    end
  end

  assign o_data    = r_data;
  assign o_valid   = r_valid;
  assign o_pending = r_pending;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC, bus read sequencing and decoder strobes.
// Define FETCH_PREFETCH_EN to add the speculative pc+1 prefetch buffer.
module instr_fetch_unit
  import cpu_fetch_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               nreset,
  output logic [ADDR_W-1:0]  bus_addr,
  output logic               bus_start,
  input  logic               bus_done,
  input  logic [INSTR_W-1:0] bus_q,
  output logic [INSTR_W-1:0] q,
  output logic               fetch,
  output logic               getRegs,
  output logic [ADDR_W-1:0]  pc,
  input  logic               exec_done,
  input  logic               jump_valid,
  input  logic [ADDR_W-1:0]  jump_addr,
  input  logic               halt,
  output logic               halted
);

  fetch_state_t       r_state, w_next_state;
  logic [ADDR_W-1:0]  r_pc, w_next_pc;
  logic [INSTR_W-1:0] r_ireg, w_next_ireg;
  logic [ADDR_W-1:0]  r_bus_addr, w_next_bus_addr;
  logic               r_bus_start, w_next_bus_start;
  logic               r_fetch, r_get_regs, r_halted;

`ifdef FETCH_PREFETCH_EN
  logic               w_pf_issue, w_pf_clear, w_pf_valid, w_pf_pending, w_pf_busy;
  logic [INSTR_W-1:0] w_pf_data;
  logic               r_drop, w_next_drop;
  logic               r_halt_after, w_next_halt_after;

  instr_prefetch_buf u_prefetch_buf (
    .clk       (clk),
    .nreset    (nreset),
    .i_issue   (w_pf_issue),
    .i_clear   (w_pf_clear),
    .i_done    (bus_done),
    .i_data    (bus_q),
    .o_data    (w_pf_data),
    .o_valid   (w_pf_valid),
    .o_pending (w_pf_pending)
  );

  // A read still in flight at retire must be drained before the bus is reused.
  assign w_pf_busy = w_pf_pending && !bus_done;
`endif

  // NOTE: every combinational output gets a default first, so no latch is inferred.
  always_comb begin
    w_next_state     = r_state;
    w_next_pc        = r_pc;
    w_next_ireg      = r_ireg;
    w_next_bus_addr  = r_bus_addr;
    w_next_bus_start = 1'b0;
`ifdef FETCH_PREFETCH_EN
    w_pf_issue        = 1'b0;
    w_pf_clear        = 1'b0;
    w_next_drop       = r_drop;
    w_next_halt_after = r_halt_after;
`endif
    unique case (r_state)
      ST_RESET:   w_next_state = ST_REQ;
      ST_REQ:     w_next_state = ST_WAIT;
      ST_WAIT: begin
`ifdef FETCH_PREFETCH_EN
        w_pf_clear = 1'b1;
        if (bus_done && r_drop) begin
          w_next_drop  = 1'b0;
          w_next_state = r_halt_after ? ST_HALTED : ST_REQ;
        end else if (bus_done) begin
          w_next_ireg  = bus_q;
          w_next_state = ST_FETCH;
        end
`else
        if (bus_done) begin
          w_next_ireg  = bus_q;
          w_next_state = ST_FETCH;
        end
`endif
      end
      ST_FETCH:   w_next_state = ST_GETREGS;
      ST_GETREGS: begin
        w_next_state = ST_HOLD;
`ifdef FETCH_PREFETCH_EN
        w_pf_issue       = 1'b1;
        w_next_bus_start = 1'b1;
        w_next_bus_addr  = r_pc + ADDR_W'(1);
`endif
      end
      ST_HOLD: begin
        if (exec_done) begin
`ifdef FETCH_PREFETCH_EN
          w_pf_clear = 1'b1;
          if (halt) begin
            w_next_halt_after = w_pf_busy;
            w_next_drop       = w_pf_busy;
            w_next_state      = w_pf_busy ? ST_WAIT : ST_HALTED;
          end else if (jump_valid) begin
            w_next_pc    = jump_addr;
            w_next_drop  = w_pf_busy;
            w_next_state = w_pf_busy ? ST_WAIT : ST_REQ;
          end else begin
            w_next_pc = r_pc + ADDR_W'(1);
            if (w_pf_valid) begin
              w_next_ireg  = w_pf_data;
              w_next_state = ST_FETCH;
            end else if (w_pf_pending && bus_done) begin
              w_next_ireg  = bus_q;
              w_next_state = ST_FETCH;
            end else if (w_pf_pending) begin
              w_next_state = ST_WAIT;
            end else begin
              w_next_state = ST_REQ;
            end
          end
`else
          if (halt) begin
            w_next_state = ST_HALTED;
          end else if (jump_valid) begin
            w_next_pc    = jump_addr;
            w_next_state = ST_REQ;
          end else begin
            w_next_pc    = r_pc + ADDR_W'(1);
            w_next_state = ST_REQ;
          end
`endif
        end
      end
      ST_HALTED:  w_next_state = ST_HALTED;
      default:    w_next_state = ST_RESET;
    endcase

    if (w_next_state == ST_REQ) begin
      w_next_bus_start = 1'b1;
      w_next_bus_addr  = w_next_pc;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state     <= ST_RESET;
      r_pc        <= RESET_PC;
      r_ireg      <= '0;
      r_bus_addr  <= RESET_PC;
      r_bus_start <= 1'b0;
      r_fetch     <= 1'b0;
      r_get_regs  <= 1'b0;
      r_halted    <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_pc        <= w_next_pc;
      r_ireg      <= w_next_ireg;
      r_bus_addr  <= w_next_bus_addr;
      r_bus_start <= w_next_bus_start;
      r_fetch     <= (w_next_state == ST_FETCH);
      r_get_regs  <= (w_next_state == ST_GETREGS);
      r_halted    <= (w_next_state == ST_HALTED);
    end
  end

`ifdef FETCH_PREFETCH_EN
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_drop       <= 1'b0;
      r_halt_after <= 1'b0;
    end else begin
      r_drop       <= w_next_drop;
      r_halt_after <= w_next_halt_after;
    end
  end
`endif

  assign bus_addr  = r_bus_addr;
  assign bus_start = r_bus_start;
  assign q         = r_ireg;
  assign fetch     = r_fetch;
  assign getRegs   = r_get_regs;
  assign pc        = r_pc;
  assign halted    = r_halted;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a latency-programmable memory model.
// Prefetch-specific sequences are compiled when FETCH_PREFETCH_EN is defined.
module tb_instr_fetch_unit;

  localparam int AW = 27;

  logic          clk;
  logic          nreset;
  logic [AW-1:0] bus_addr;
  logic          bus_start;
  logic          bus_done;
  logic [31:0]   bus_q;
  logic [31:0]   q;
  logic          fetch;
  logic          getRegs;
  logic [AW-1:0] pc;
  logic          exec_done;
  logic          jump_valid;
  logic [AW-1:0] jump_addr;
  logic          halt;
  logic          halted;

  int n_checks = 0;
  int n_fail   = 0;

  int            mem_lat = 1;
  int            mem_cnt = 0;
  bit            mem_busy = 0;
  logic [AW-1:0] mem_addr;
  logic [AW-1:0] addr_log[$];
  int            start_cnt = 0;
  int            fetch_cnt = 0;
  int            gr_cnt    = 0;
  int            excl_err  = 0;

  instr_fetch_unit #(.ADDR_W(AW), .RESET_PC('0)) dut (
    .clk        (clk),
    .nreset     (nreset),
    .bus_addr   (bus_addr),
    .bus_start  (bus_start),
    .bus_done   (bus_done),
    .bus_q      (bus_q),
    .q          (q),
    .fetch      (fetch),
    .getRegs    (getRegs),
    .pc         (pc),
    .exec_done  (exec_done),
    .jump_valid (jump_valid),
    .jump_addr  (jump_addr),
    .halt       (halt),
    .halted     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [AW-1:0] a);
    return {5'b10101, a};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Memory: bus_done arrives mem_lat cycles after the bus_start cycle.
  initial begin
    bus_done = 1'b0;
    bus_q    = '0;
    forever begin
      @(negedge clk);
      bus_done = 1'b0;
      if (!nreset) begin
        mem_busy = 0;
      end else begin
        if (mem_busy) begin
          mem_cnt--;
          if (mem_cnt == 0) begin
            bus_done = 1'b1;
            bus_q    = word(mem_addr);
            mem_busy = 0;
          end
        end
        if (bus_start) begin
          mem_busy = 1;
          mem_cnt  = mem_lat;
          mem_addr = bus_addr;
          addr_log.push_back(bus_addr);
          start_cnt++;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (fetch === 1'b1) fetch_cnt++;
    if (getRegs === 1'b1) gr_cnt++;
    if (fetch === 1'b1 && getRegs === 1'b1) excl_err++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // sel: 0 = getRegs, 1 = bus_start, 2 = halted
  task automatic wait_for(input int sel, input string tag);
    bit seen = 0;
    for (int i = 0; i < 60; i++) begin
      case (sel)
        0:       seen = (getRegs === 1'b1);
        1:       seen = (bus_start === 1'b1);
        default: seen = (halted === 1'b1);
      endcase
      if (seen) break;
      @(negedge clk);
    end
    check(tag, 32'(seen), 32'd1);
  endtask

  // Called from a negedge in HOLD; returns at the negedge after the sampling edge.
  task automatic retire(input bit jv, input logic [AW-1:0] ja, input bit h);
    exec_done  = 1'b1;
    jump_valid = jv;
    jump_addr  = ja;
    halt       = h;
    @(negedge clk);
    exec_done  = 1'b0;
    jump_valid = 1'b0;
    jump_addr  = '0;
    halt       = 1'b0;
  endtask

  initial begin
    int f0;
    int s0;
    nreset     = 1'b0;
    exec_done  = 1'b0;
    jump_valid = 1'b0;
    jump_addr  = '0;
    halt       = 1'b0;
    step(2);
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_q", q, 32'd0);
    check("rst_bus_addr", 32'(bus_addr), 32'd0);
    check("rst_strobes", {28'd0, bus_start, fetch, getRegs, halted}, 32'd0);
    nreset = 1'b1;

    // Sequential fetch of 0,1,2, then jump from the third instruction.
    for (int i = 0; i < 3; i++) begin
      wait_for(0, "seq_getregs");
      check("seq_q", q, word(AW'(i)));
      check("seq_pc", 32'(pc), 32'(i));
      step(1);
      if (i < 2) retire(1'b0, '0, 1'b0);
      else       retire(1'b1, AW'(27'h000_1234), 1'b0);
    end
    check("seq_addr0", 32'(addr_log[0]), 32'd0);
    check("seq_addr1", 32'(addr_log[1]), 32'd1);
    check("seq_addr2", 32'(addr_log[2]), 32'd2);
    check("seq_fetch_cnt", 32'(fetch_cnt), 32'd3);
    check("seq_getregs_cnt", 32'(gr_cnt), 32'd3);

`ifndef FETCH_PREFETCH_EN
    check("jump_req_latency", 32'(bus_start), 32'd1);
`endif
    wait_for(1, "jump_req");
    check("jump_bus_addr", 32'(bus_addr), 32'h1234);
    check("jump_pc", 32'(pc), 32'h1234);
    wait_for(0, "jump_getregs");
    check("jump_q", q, word(AW'(27'h1234)));

    // PC wrap from all-ones.
    step(1);
    retire(1'b1, AW'(27'h7FF_FFFF), 1'b0);
    wait_for(0, "wrap_getregs0");
    check("wrap_pc_top", 32'(pc), 32'h07FF_FFFF);
    step(1);
    retire(1'b0, '0, 1'b0);
    wait_for(0, "wrap_getregs1");
    check("wrap_pc", 32'(pc), 32'd0);
    check("wrap_q", q, word('0));
    check("wrap_bus_addr", 32'(addr_log[$]), 32'd0);

`ifndef FETCH_PREFETCH_EN
    // Five-cycle memory: WAIT holds q, fetch one cycle after bus_done.
    mem_lat = 5;
    step(1);
    retire(1'b0, '0, 1'b0);
    check("lat_req", 32'(bus_start), 32'd1);
    check("lat_req_addr", 32'(bus_addr), 32'd1);
    for (int i = 0; i < 5; i++) begin
      step(1);
      check("lat_q_hold", q, word('0));
      check("lat_no_fetch", 32'(fetch), 32'd0);
    end
    step(1);
    check("lat_fetch", 32'(fetch), 32'd1);
    check("lat_q_new", q, word(AW'(1)));
`else
    // Prefetched sequential retire: fetch one cycle after exec_done.
    mem_lat = 1;
    step(3);
    retire(1'b0, '0, 1'b0);
    check("pf_fetch_latency", 32'(fetch), 32'd1);
    check("pf_q", q, word(AW'(1)));
    check("pf_pc", 32'(pc), 32'd1);
    // Jump while the speculative read is outstanding.
    mem_lat = 5;
    wait_for(0, "pf_getregs1");
    step(1);
    f0 = fetch_cnt;
    retire(1'b1, AW'(27'h2345), 1'b0);
    wait_for(0, "pf_jump_getregs");
    check("pf_jump_pc", 32'(pc), 32'h2345);
    check("pf_jump_q", q, word(AW'(27'h2345)));
    check("pf_jump_one_fetch", 32'(fetch_cnt - f0), 32'd1);
    check("pf_stale_addr", 32'(addr_log[addr_log.size()-2]), 32'd2);
    check("pf_jump_addr", 32'(addr_log[$]), 32'h2345);
`endif

    // Reset asserted mid-WAIT.
    mem_lat = 5;
    wait_for(0, "rstw_getregs");
    step(1);
    retire(1'b0, '0, 1'b0);
    step(2);
    nreset = 1'b0;
    #1;
    check("rstw_pc", 32'(pc), 32'd0);
    check("rstw_q", q, 32'd0);
    check("rstw_bus_addr", 32'(bus_addr), 32'd0);
    check("rstw_strobes", {28'd0, bus_start, fetch, getRegs, halted}, 32'd0);
    step(2);
    nreset  = 1'b1;
    mem_lat = 1;
    wait_for(0, "post_rst_getregs");
    check("post_rst_q", q, word('0));
    check("post_rst_pc", 32'(pc), 32'd0);

    // halt wins over jump_valid; no further reads afterwards.
    step(1);
    retire(1'b1, AW'(27'h55), 1'b1);
    wait_for(2, "halt_seen");
    check("halt_pc", 32'(pc), 32'd0);
    s0 = start_cnt;
    f0 = fetch_cnt;
    step(10);
    check("halt_no_start", 32'(start_cnt), 32'(s0));
    check("halt_no_fetch", 32'(fetch_cnt), 32'(f0));
    check("halt_sticky", 32'(halted), 32'd1);
    check("fetch_getregs_exclusive", 32'(excl_err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
